// File: rtl/operand_fetch.sv
// operand_fetch: hazard-checked operand read with writeback forwarding and a registered execute stage
module operand_fetch #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  id_valid_i,
  output logic                  id_ready_o,
  input  logic [ADDR_WIDTH-1:0] id_rs1_i,
  input  logic [ADDR_WIDTH-1:0] id_rs2_i,
  input  logic [ADDR_WIDTH-1:0] id_rd_i,
  input  logic                  id_rd_we_i,
  output logic [ADDR_WIDTH-1:0] rf_raddr_a_o,
  input  logic [DATA_WIDTH-1:0] rf_rdata_a_i,
  output logic [ADDR_WIDTH-1:0] rf_raddr_b_o,
  input  logic [DATA_WIDTH-1:0] rf_rdata_b_i,
  input  logic [ADDR_WIDTH-1:0] wb_waddr_i,
  input  logic [DATA_WIDTH-1:0] wb_wdata_i,
  input  logic                  wb_we_i,
  output logic                  ex_valid_o,
  input  logic                  ex_ready_i,
  output logic [DATA_WIDTH-1:0] ex_op_a_o,
  output logic [DATA_WIDTH-1:0] ex_op_b_o,
  output logic [ADDR_WIDTH-1:0] ex_rd_o,
  output logic                  ex_rd_we_o
);
  logic [NUM_WORDS-1:0]  busy_q, busy_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                  rd_we_q, rd_we_d;
  logic                  wb_en, hit1, hit2, hitd, raw, waw, accept;
  logic [DATA_WIDTH-1:0] fwd_a, fwd_b;

  assign rf_raddr_a_o = id_rs1_i;
  assign rf_raddr_b_o = id_rs2_i;
  assign ex_valid_o   = valid_q;
  assign ex_op_a_o    = op_a_q;
  assign ex_op_b_o    = op_b_q;
  assign ex_rd_o      = rd_q;
  assign ex_rd_we_o   = rd_we_q;

  // hazard detection, forwarding and handshake; x0 is excluded explicitly so it can never stall or forward
  always_comb begin
    wb_en      = wb_we_i && wb_waddr_i != '0;
    hit1       = wb_en && wb_waddr_i == id_rs1_i;
    hit2       = wb_en && wb_waddr_i == id_rs2_i;
    hitd       = wb_en && wb_waddr_i == id_rd_i;
    raw        = (id_rs1_i != '0 && busy_q[id_rs1_i] && !hit1) ||
                 (id_rs2_i != '0 && busy_q[id_rs2_i] && !hit2);
    waw        = id_rd_we_i && id_rd_i != '0 && busy_q[id_rd_i] && !hitd;
    id_ready_o = !flush_i && (!valid_q || ex_ready_i) && !raw && !waw;
    accept     = id_valid_i && id_ready_o;
    fwd_a      = id_rs1_i == '0 ? '0 : hit1 ? wb_wdata_i : rf_rdata_a_i;
    fwd_b      = id_rs2_i == '0 ? '0 : hit2 ? wb_wdata_i : rf_rdata_b_i;
  end

  // next state: output stage loads on accept, holds under backpressure, drains on consume; set beats clear in the scoreboard
  always_comb begin
    valid_d = flush_i ? 1'b0 : accept ? 1'b1 : ex_ready_i ? 1'b0 : valid_q;
    op_a_d  = accept ? fwd_a : op_a_q;
    op_b_d  = accept ? fwd_b : op_b_q;
    rd_d    = accept ? id_rd_i : rd_q;
    rd_we_d = accept ? id_rd_we_i : rd_we_q;
    busy_d  = busy_q;
    if (wb_en) busy_d[wb_waddr_i] = 1'b0;
    if (accept && id_rd_we_i && id_rd_i != '0) busy_d[id_rd_i] = 1'b1;
    if (flush_i) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  // state registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q  <= '0;
      valid_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      rd_q    <= '0;
      rd_we_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      valid_q <= valid_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      rd_q    <= rd_d;
      rd_we_q <= rd_we_d;
    end
  end
endmodule
